game_lane_judge: RTL and testbench

Parametrised successor to the game-mode falling-note renderer. It scrolls notes down LANES vertical lanes and renders them per pixel for the VGA timing block. Unlike the single-bit judge it replaces, it scores every note exactly once as hit or miss, with saturating hit, miss and combo counters, a pause mode, a synchronous clear, and a judge line. It sits between the note sequencer/key decoder and the VGA pixel mux.

---
 rtl/game_lane_judge.sv | 143 ++++++++++++++
 tb/tb_game_lane_judge.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_lane_judge.sv
// Falling-note lane renderer and judge: scrolls notes down LANES columns, scores each note
// once as hit or miss with saturating counters, and renders a registered pixel colour.
module game_lane_judge #(
  parameter int unsigned LANES       = 7,
  parameter int unsigned DEPTH       = 400,
  parameter int unsigned TICK_PERIOD = 100000,
  parameter int unsigned LANE_X0     = 112,
  parameter int unsigned LANE_PITCH  = 64,
  parameter int unsigned LANE_W      = 32,
  parameter int unsigned SCORE_W     = 16,
  parameter logic [23:0] BG_COLOR    = 24'hFFFFFF,
  parameter logic [23:0] BLOCK_COLOR = 24'h000000,
  parameter logic [23:0] HIT_COLOR   = 24'hFFF200,
  parameter logic [23:0] LINE_COLOR  = 24'hFF0000
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  input  logic [LANES-1:0]   note,
  input  logic               note_valid,
  input  logic [LANES-1:0]   key,
  input  logic               pause,
  input  logic               clear,
  output logic [23:0]        pos_data,
  output logic [LANES-1:0]   lane_bottom,
  output logic               tick,
  output logic [SCORE_W-1:0] hit_count,
  output logic [SCORE_W-1:0] miss_count,
  output logic [SCORE_W-1:0] combo
);

  localparam int unsigned CW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int unsigned RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (LANE_PITCH < LANE_W) begin : g_pitch_check
    $error("LANE_PITCH must be >= LANE_W so lanes do not overlap");
  end

  logic [DEPTH-1:0] col [LANES];
  logic [LANES-1:0] judged;
  logic [LANES-1:0] key_d;
  logic [CW-1:0]    cnt;
  logic             tick_r;

  logic [LANES-1:0] key_rise;
  logic [LANES-1:0] hits;
  logic [LANES-1:0] misses;
  logic [LANES-1:0] stray;
  logic [23:0]      pix_next;
  logic [RW-1:0]    row;

  function automatic logic [SCORE_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [SCORE_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < LANES; i++) c = c + SCORE_W'(v[i]);
    return c;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  // A pending tick is swallowed while paused so nothing scrolls or judges.
  assign tick = tick_r & ~pause;
  assign row  = pos_y[RW-1:0];

  always_comb begin
    lane_bottom = '0;
    for (int unsigned l = 0; l < LANES; l++) lane_bottom[l] = col[l][DEPTH-1];
  end

  // A hit on the tick cycle is judged against the pre-shift bottom and masks that note's miss.
  always_comb begin
    key_rise = key & ~key_d & {LANES{~pause}};
    hits     = key_rise & lane_bottom & ~judged;
    stray    = key_rise & ~(lane_bottom & ~judged);
    misses   = {LANES{tick}} & lane_bottom & ~judged & ~hits;
  end

  always_comb begin
    pix_next = BG_COLOR;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (32'(pos_x) >= LANE_X0 + l * LANE_PITCH &&
          32'(pos_x) <  LANE_X0 + l * LANE_PITCH + LANE_W) begin
        if (32'(pos_y) < DEPTH) begin
          if (col[l][row])
            pix_next = (32'(pos_y) == DEPTH - 1 && judged[l]) ? HIT_COLOR : BLOCK_COLOR;
        end else if (32'(pos_y) < DEPTH + 2) begin
          pix_next = key[l] ? HIT_COLOR : LINE_COLOR;
        end
      end
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned l = 0; l < LANES; l++) col[l] <= '0;
      judged     <= '0;
      key_d      <= '0;
      cnt        <= '0;
      tick_r     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      combo      <= '0;
      pos_data   <= BG_COLOR;
    end else if (clear) begin
      for (int unsigned l = 0; l < LANES; l++) col[l] <= '0;
      judged     <= '0;
      key_d      <= '0;
      cnt        <= '0;
      tick_r     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      combo      <= '0;
      pos_data   <= BG_COLOR;
    end else begin
      key_d <= key;
      if (pause) begin
        tick_r <= 1'b0;
      end else if (cnt == CW'(TICK_PERIOD - 1)) begin
        cnt    <= '0;
        tick_r <= 1'b1;
      end else begin
        cnt    <= cnt + 1'b1;
        tick_r <= 1'b0;
      end
      if (tick) begin
        for (int unsigned l = 0; l < LANES; l++)
          col[l] <= {col[l][DEPTH-2:0], note[l] & note_valid};
      end
      judged     <= tick ? '0 : (judged | hits);
      hit_count  <= sat_add(hit_count, popcount(hits));
      miss_count <= sat_add(miss_count, popcount(misses));
      combo      <= (|misses || |stray) ? '0 : sat_add(combo, popcount(hits));
      pos_data   <= pix_next;
    end
  end

endmodule

// File: tb/tb_game_lane_judge.sv
// Directed bench for game_lane_judge with LANES=7, DEPTH=8, TICK_PERIOD=4.
module tb_game_lane_judge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pos_x = '0;
  logic [9:0]  pos_y = '0;
  logic [6:0]  note = '0;
  logic        note_valid = 1'b0;
  logic [6:0]  key = '0;
  logic        pause = 1'b0;
  logic        clear = 1'b0;
  logic [23:0] pos_data;
  logic [6:0]  lane_bottom;
  logic        tick;
  logic [15:0] hit_count, miss_count, combo;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [6:0]  k;
    logic [23:0] exp;
  } pix_vec_t;

  pix_vec_t tbl [13];

  game_lane_judge #(.LANES(7), .DEPTH(8), .TICK_PERIOD(4)) dut (
    .vga_clk(clk), .rst_n(rst_n), .pos_x(pos_x), .pos_y(pos_y),
    .note(note), .note_valid(note_valid), .key(key), .pause(pause), .clear(clear),
    .pos_data(pos_data), .lane_bottom(lane_bottom), .tick(tick),
    .hit_count(hit_count), .miss_count(miss_count), .combo(combo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic next_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < 20);
    chk("tick_seen", 32'(tick), 1);
  endtask

  // Advance to the next tick and let its scroll edge happen.
  task automatic do_tick();
    int n;
    next_tick(n);
    step();
  endtask

  task automatic inject(input logic [6:0] n_in);
    int n;
    next_tick(n);
    note = n_in;
    note_valid = 1'b1;
    step();
    note = '0;
    note_valid = 1'b0;
  endtask

  initial begin
    int n;
    tbl[0]  = '{10'd176, 10'd2,  7'b0000000, 24'h000000};
    tbl[1]  = '{10'd175, 10'd2,  7'b0000000, 24'hFFFFFF};
    tbl[2]  = '{10'd207, 10'd2,  7'b0000000, 24'h000000};
    tbl[3]  = '{10'd208, 10'd2,  7'b0000000, 24'hFFFFFF};
    tbl[4]  = '{10'd176, 10'd3,  7'b0000000, 24'hFFFFFF};
    tbl[5]  = '{10'd176, 10'd8,  7'b0000010, 24'hFFF200};
    tbl[6]  = '{10'd176, 10'd9,  7'b0000000, 24'hFF0000};
    tbl[7]  = '{10'd176, 10'd10, 7'b0000000, 24'hFFFFFF};
    tbl[8]  = '{10'd112, 10'd8,  7'b0000000, 24'hFF0000};
    tbl[9]  = '{10'd0,   10'd8,  7'b0000000, 24'hFFFFFF};
    tbl[10] = '{10'd111, 10'd9,  7'b0000000, 24'hFFFFFF};
    tbl[11] = '{10'd496, 10'd9,  7'b1000000, 24'hFFF200};
    tbl[12] = '{10'd528, 10'd9,  7'b1000000, 24'hFFFFFF};

    // reset state
    repeat (3) step();
    chk("rst_pos_data", pos_data, 24'hFFFFFF);
    chk("rst_hit", hit_count, 0);
    chk("rst_miss", miss_count, 0);
    chk("rst_combo", combo, 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_bottom", lane_bottom, 0);
    #3 rst_n = 1'b1;

    // 1: note reaches the bottom 7 ticks after injection; 4-cycle tick period
    inject(7'b0000001);
    next_tick(n);
    chk("tick_period", n, 3);
    step();
    for (int i = 0; i < 5; i++) do_tick();
    chk("bottom_before", lane_bottom, 0);
    do_tick();
    chk("bottom_lane0", lane_bottom, 7'b0000001);

    // 2: hit, then hold the key across a tick
    key = 7'b0000001;
    step();
    chk("hit1_hit", hit_count, 1);
    chk("hit1_combo", combo, 1);
    chk("hit1_miss", miss_count, 0);
    do_tick();
    chk("held_hit", hit_count, 1);
    chk("held_miss", miss_count, 0);
    chk("held_bottom", lane_bottom, 0);
    do_tick();
    chk("held_hit2", hit_count, 1);
    key = '0;

    // 3: lane-3 note passes unplayed
    inject(7'b0001000);
    for (int i = 0; i < 7; i++) do_tick();
    chk("bottom_lane3", lane_bottom, 7'b0001000);
    next_tick(n);
    chk("miss_pre", miss_count, 0);
    step();
    chk("miss_count", miss_count, 1);
    chk("miss_combo", combo, 0);
    chk("miss_hit", hit_count, 1);

    // 4: two key rises on the tick cycle
    inject(7'b0000011);
    for (int i = 0; i < 7; i++) do_tick();
    chk("bottom_lane01", lane_bottom, 7'b0000011);
    next_tick(n);
    key = 7'b0000011;
    step();
    chk("tickhit_hit", hit_count, 3);
    chk("tickhit_miss", miss_count, 1);
    chk("tickhit_combo", combo, 2);
    key = '0;

    // 5: build combo to 3, then a stray press
    inject(7'b0000100);
    for (int i = 0; i < 7; i++) do_tick();
    key = 7'b0000100;
    step();
    chk("c3_hit", hit_count, 4);
    chk("c3_combo", combo, 3);
    key = '0;
    step();
    key = 7'b0010000;
    step();
    chk("stray_combo", combo, 0);
    chk("stray_hit", hit_count, 4);
    chk("stray_miss", miss_count, 1);
    key = '0;
    step();
    chk("stray_nomiss", miss_count, 1);

    // pause freezes scroll, tick and judging
    inject(7'b0100000);
    for (int i = 0; i < 7; i++) do_tick();
    chk("bottom_lane5", lane_bottom, 7'b0100000);
    pause = 1'b1;
    key = 7'b0100000;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("pause_tick", 32'(tick), 0);
    end
    chk("pause_hit", hit_count, 4);
    chk("pause_bottom", lane_bottom, 7'b0100000);
    key = '0;
    step();
    pause = 1'b0;
    do_tick();
    chk("unpause_miss", miss_count, 2);
    chk("unpause_bottom", lane_bottom, 0);

    // synchronous clear
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_hit", hit_count, 0);
    chk("clr_miss", miss_count, 0);
    chk("clr_combo", combo, 0);

    // 6: pixel table with lane-1 note frozen at row 2
    inject(7'b0000010);
    do_tick();
    do_tick();
    pause = 1'b1;
    for (int i = 0; i < 13; i++) begin
      pos_x = tbl[i].x;
      pos_y = tbl[i].y;
      key = tbl[i].k;
      step();
      chk($sformatf("pix%0d", i), pos_data, tbl[i].exp);
    end
    key = '0;
    pos_x = 10'd176;
    pos_y = 10'd7;
    step();
    pause = 1'b0;
    for (int i = 0; i < 5; i++) do_tick();
    step();
    chk("pix_bottom_block", pos_data, 24'h000000);
    key = 7'b0000010;
    step();
    step();
    chk("pix_bottom_hit", pos_data, 24'hFFF200);
    chk("pix_hit_count", hit_count, 1);

    // async reset mid-frame
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pos_data", pos_data, 24'hFFFFFF);
    chk("arst_hit", hit_count, 0);
    chk("arst_combo", combo, 0);
    chk("arst_bottom", lane_bottom, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
